// File: rtl/io_pwr_seq_pkg.sv
// Shared types and helpers for the IO pad-ring power sequencer.
//   io_pwr_state_e   : sequencer state encoding
//   SYNC_STAGES      : depth of the pg_i synchronizer
//   lowest_set_idx   : index of the least significant set bit (0 if none)
//   highest_set_idx  : index of the most significant set bit (0 if none)
package io_pwr_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitPg,
    StSettle,
    StActive,
    StShutdown,
    StFault
  } io_pwr_state_e;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned MAX_BANKS   = 16;

  function automatic logic [3:0] lowest_set_idx(input logic [MAX_BANKS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_BANKS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] highest_set_idx(input logic [MAX_BANKS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_BANKS; i++) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/io_pwr_seq_sync.sv
// Multi-flop synchronizer for asynchronous level inputs.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, all stages clear to 0
//   d_i    : asynchronous input bits
//   q_o    : synchronized bits, Stages cycles of latency
module io_pwr_seq_sync #(
  parameter int unsigned Width  = 1,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] sync_d, sync_q;

  always_comb begin
    sync_d = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < Stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/io_pwr_seq.sv
// Power-up / power-down sequencer for the 1.8 V IO pad ring.
// Brings pad banks up one at a time, each gated by its synchronized supply-good flag and
// followed by a programmable settle delay; releases pad_oe_o once all banks are up; unwinds
// in reverse order on stop_i; drops everything on supply loss of an enabled bank.
// Optional build macro IO_PWR_SEQ_TIMEOUT_EN adds a power-good wait timeout.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   start_i          : begin power-up (honoured in idle only)
//   stop_i           : begin orderly power-down
//   clear_i          : leave the fault state
//   pg_i             : per-bank supply-good flags (asynchronous)
//   settle_cyc_i     : settle delay per bank (quasi-static)
//   bank_en_o        : per-bank enables
//   pad_oe_o         : global pad output enable
//   busy_o / done_o / fault_o : sequencing / all up / faulted
//   fault_bank_o     : lowest failing bank index
//   timeout_o        : fault was a power-good timeout
module io_pwr_seq
  import io_pwr_seq_pkg::*;
#(
  parameter int unsigned N_BANKS     = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic                       clear_i,
  input  logic [N_BANKS-1:0]         pg_i,
  input  logic [CNT_W-1:0]           settle_cyc_i,
  output logic [N_BANKS-1:0]         bank_en_o,
  output logic                       pad_oe_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       fault_o,
  output logic [$clog2(N_BANKS)-1:0] fault_bank_o,
  output logic                       timeout_o
);

  localparam int unsigned IdxW = $clog2(N_BANKS);

  logic [N_BANKS-1:0] pg_s;

  io_pwr_seq_sync #(
    .Width (N_BANKS),
    .Stages(SYNC_STAGES)
  ) u_pg_sync (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .d_i   (pg_i),
    .q_o   (pg_s)
  );

  io_pwr_state_e      state_d, state_q;
  logic [IdxW-1:0]    idx_d, idx_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;
  logic [N_BANKS-1:0] bank_en_d, bank_en_q;
  logic               pad_oe_d, pad_oe_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               fault_d, fault_q;
  logic [IdxW-1:0]    fault_bank_d, fault_bank_q;

  logic [N_BANKS-1:0] lost;
  logic [IdxW-1:0]    hi_idx;
  logic               wait_expired;

`ifdef IO_PWR_SEQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
  logic [WaitW-1:0] wcnt_d, wcnt_q;
  logic             timeout_d, timeout_q;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    bank_en_d    = bank_en_q;
    pad_oe_d     = pad_oe_q;
    fault_bank_d = fault_bank_q;
    lost         = bank_en_q & ~pg_s;
    hi_idx       = IdxW'(highest_set_idx(16'(bank_en_q)));
`ifdef IO_PWR_SEQ_TIMEOUT_EN
    wcnt_d       = wcnt_q;
    timeout_d    = timeout_q;
    // pg_s arriving on the last allowed cycle still counts as in time.
    wait_expired = ~pg_s[idx_q] && (wcnt_q == WaitW'(TIMEOUT_CYC - 1));
`else
    wait_expired = 1'b0;
`endif

    if ((state_q != StIdle) && (state_q != StFault) && (|lost)) begin
      // Supply loss on an enabled bank overrides everything else.
      state_d      = StFault;
      bank_en_d    = '0;
      pad_oe_d     = 1'b0;
      fault_bank_d = IdxW'(lowest_set_idx(16'(lost)));
`ifdef IO_PWR_SEQ_TIMEOUT_EN
      timeout_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_d = StWaitPg;
            idx_d   = '0;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
            wcnt_d  = '0;
`endif
          end
        end
        StWaitPg: begin
          if (wait_expired) begin
            state_d      = StFault;
            bank_en_d    = '0;
            pad_oe_d     = 1'b0;
            fault_bank_d = idx_q;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
            timeout_d    = 1'b1;
`endif
          end else if (stop_i) begin
            state_d  = StShutdown;
            pad_oe_d = 1'b0;
            cnt_d    = settle_cyc_i;
          end else if (pg_s[idx_q]) begin
            state_d = StSettle;
            cnt_d   = settle_cyc_i;
          end
`ifdef IO_PWR_SEQ_TIMEOUT_EN
          else begin
            wcnt_d = wcnt_q + WaitW'(1);
          end
`endif
        end
        StSettle: begin
          if (stop_i) begin
            // The bank currently settling is abandoned, never enabled.
            state_d  = StShutdown;
            pad_oe_d = 1'b0;
            cnt_d    = settle_cyc_i;
          end else if (cnt_q == '0) begin
            bank_en_d[idx_q] = 1'b1;
            if (idx_q == IdxW'(N_BANKS - 1)) begin
              state_d  = StActive;
              pad_oe_d = 1'b1;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              state_d = StWaitPg;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
              wcnt_d  = '0;
`endif
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StActive: begin
          if (stop_i) begin
            state_d  = StShutdown;
            pad_oe_d = 1'b0;
            cnt_d    = settle_cyc_i;
          end
        end
        StShutdown: begin
          if (bank_en_q == '0) begin
            state_d = StIdle;
          end else if (cnt_q == '0) begin
            // Highest enabled bank goes first, then the delay restarts.
            bank_en_d[hi_idx] = 1'b0;
            cnt_d             = settle_cyc_i;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        StFault: begin
          if (clear_i) begin
            state_d      = StIdle;
            fault_bank_d = '0;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
            timeout_d    = 1'b0;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d  = (state_d == StWaitPg) || (state_d == StSettle) || (state_d == StShutdown);
    done_d  = (state_d == StActive);
    fault_d = (state_d == StFault);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cnt_q        <= '0;
      bank_en_q    <= '0;
      pad_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
      fault_bank_q <= '0;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
      wcnt_q       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      bank_en_q    <= bank_en_d;
      pad_oe_q     <= pad_oe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fault_q      <= fault_d;
      fault_bank_q <= fault_bank_d;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
      wcnt_q       <= wcnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign bank_en_o    = bank_en_q;
  assign pad_oe_o     = pad_oe_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign fault_o      = fault_q;
  assign fault_bank_o = fault_bank_q;

`ifdef IO_PWR_SEQ_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  // No wait counter in this build; the limit is still referenced so both builds accept the
  // same parameter set.
  localparam bit TimeoutLimitSet = (TIMEOUT_CYC != 0);
  assign timeout_o = 1'b0 & TimeoutLimitSet;
`endif

endmodule

// File: tb/tb_io_pwr_seq.sv
module tb_io_pwr_seq;

  localparam int NB = 4;
  localparam int CW = 8;
  localparam int TO = 16;

  localparam int MIdle   = 0;
  localparam int MWait   = 1;
  localparam int MSettle = 2;
  localparam int MActive = 3;
  localparam int MShut   = 4;
  localparam int MFault  = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          stop_i = 1'b0;
  logic          clear_i = 1'b0;
  logic [NB-1:0] pg_i = '0;
  logic [CW-1:0] settle_cyc_i = '0;
  logic [NB-1:0] bank_en_o;
  logic          pad_oe_o;
  logic          busy_o;
  logic          done_o;
  logic          fault_o;
  logic [1:0]    fault_bank_o;
  logic          timeout_o;

  io_pwr_seq #(
    .N_BANKS    (NB),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .stop_i      (stop_i),
    .clear_i     (clear_i),
    .pg_i        (pg_i),
    .settle_cyc_i(settle_cyc_i),
    .bank_en_o   (bank_en_o),
    .pad_oe_o    (pad_oe_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fault_o     (fault_o),
    .fault_bank_o(fault_bank_o),
    .timeout_o   (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (deadline based, edge-indexed) ----------------
  int            cyc = 0;
  int            m_mode;
  int            m_bank;
  int            m_due;
  int            m_wait_since;
  int            m_fbank;
  logic [NB-1:0] m_en;
  logic          m_oe, m_flt, m_tout;
  logic [NB-1:0] m_h0, m_h1;

  task automatic model_reset();
    m_mode = MIdle; m_bank = 0; m_due = 0; m_wait_since = 0; m_fbank = 0;
    m_en = '0; m_oe = 1'b0; m_flt = 1'b0; m_tout = 1'b0; m_h0 = '0; m_h1 = '0;
  endtask

  task automatic model_shutdown();
    m_mode = MShut;
    m_oe   = 1'b0;
    m_due  = cyc + int'(settle_cyc_i) + 1;
  endtask

  task automatic model_step();
    logic [NB-1:0] pgs, lost;
    pgs  = m_h1;  // value pg_i had two edges ago
    m_h1 = m_h0;
    m_h0 = pg_i;
    lost = m_en & ~pgs;
    if (m_mode != MIdle && m_mode != MFault && lost != '0) begin
      m_mode = MFault; m_flt = 1'b1; m_oe = 1'b0; m_en = '0; m_tout = 1'b0;
      for (int i = NB - 1; i >= 0; i--) if (lost[i]) m_fbank = i;
    end else begin
      case (m_mode)
        MIdle: if (start_i) begin
          m_mode = MWait; m_bank = 0; m_wait_since = cyc;
        end
        MWait: begin
`ifdef IO_PWR_SEQ_TIMEOUT_EN
          if (!pgs[m_bank] && (cyc - m_wait_since >= TO)) begin
            m_mode = MFault; m_flt = 1'b1; m_oe = 1'b0; m_en = '0;
            m_tout = 1'b1; m_fbank = m_bank;
          end else
`endif
          if (stop_i) model_shutdown();
          else if (pgs[m_bank]) begin
            m_mode = MSettle;
            m_due  = cyc + int'(settle_cyc_i) + 1;
          end
        end
        MSettle: begin
          if (stop_i) model_shutdown();
          else if (cyc == m_due) begin
            m_en[m_bank] = 1'b1;
            if (m_bank == NB - 1) begin
              m_mode = MActive; m_oe = 1'b1;
            end else begin
              m_bank++; m_mode = MWait; m_wait_since = cyc;
            end
          end
        end
        MActive: if (stop_i) model_shutdown();
        MShut: begin
          if (m_en == '0) m_mode = MIdle;
          else if (cyc == m_due) begin
            for (int i = NB - 1; i >= 0; i--) begin
              if (m_en[i]) begin
                m_en[i] = 1'b0;
                break;
              end
            end
            m_due = cyc + int'(settle_cyc_i) + 1;
          end
        end
        MFault: if (clear_i) begin
          m_mode = MIdle; m_flt = 1'b0; m_fbank = 0; m_tout = 1'b0;
        end
        default: m_mode = MIdle;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) model_reset();
      else begin
        cyc++;
        model_step();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      check("bank_en", int'(bank_en_o), int'(m_en));
      check("pad_oe", int'(pad_oe_o), int'(m_oe));
      check("busy", int'(busy_o), int'(m_mode == MWait || m_mode == MSettle || m_mode == MShut));
      check("done", int'(done_o), int'(m_mode == MActive));
      check("fault", int'(fault_o), int'(m_flt));
      check("fault_bank", int'(fault_bank_o), m_fbank);
      check("timeout", int'(timeout_o), int'(m_tout));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  logic [NB-1:0] sticky_en;
  logic          sticky_oe;

  task automatic tick();
    @(negedge clk_i);
    sticky_en = sticky_en | bank_en_o;
    sticky_oe = sticky_oe | pad_oe_o;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic bit cond(input int sel, input logic [NB-1:0] v);
    case (sel)
      0: return done_o;
      1: return fault_o;
      2: return !busy_o && !done_o && !fault_o;
      default: return bank_en_o == v;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic [NB-1:0] v, input int max, input string nm);
    int n;
    n = 0;
    while (!cond(sel, v) && n < max) begin
      tick();
      n++;
    end
    check(nm, int'(cond(sel, v)), 1);
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask
  task automatic pulse_stop();
    stop_i = 1'b1; tick(); stop_i = 1'b0;
  endtask
  task automatic pulse_clear();
    clear_i = 1'b1; tick(); clear_i = 1'b0;
  endtask

  initial begin
    logic [NB-1:0] seq[$];
    logic [NB-1:0] exp_seq[4];
    logic [NB-1:0] last;
    int            set_edge[NB];
    int            rise[NB];
    bit            seen[NB];
    int            t0, e;

    sticky_en = '0;
    sticky_oe = 1'b0;
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0011; exp_seq[2] = 4'b0111; exp_seq[3] = 4'b1111;

    // Reset state
    #2;
    check("rst_bank_en", int'(bank_en_o), 0);
    check("rst_pad_oe", int'(pad_oe_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_fault", int'(fault_o), 0);
    check("rst_fault_bank", int'(fault_bank_o), 0);
    check("rst_timeout", int'(timeout_o), 0);
    tickn(2);
    rst_ni = 1'b1;

    // Normal power-up, settle=3, all supplies good
    pg_i = 4'b1111; settle_cyc_i = 8'd3;
    tickn(3);
    pulse_start();
    last = bank_en_o;
    for (int i = 0; i < 60 && bank_en_o != 4'b1111; i++) begin
      tick();
      if (bank_en_o != last) seq.push_back(bank_en_o);
      last = bank_en_o;
    end
    check("pu_steps", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++) check("pu_step_val", int'(seq[i]), int'(exp_seq[i]));
    check("pu_pad_oe", int'(pad_oe_o), 1);
    check("pu_done", int'(done_o), 1);

    // Orderly power-down from ACTIVE
    pulse_stop();
    check("sd_pad_oe", int'(pad_oe_o), 0);
    wait_for(2, '0, 100, "sd_idle");

    // Staggered supplies
    pg_i = '0;
    tickn(3);
    for (int i = 0; i < NB; i++) begin
      seen[i] = 1'b0; rise[i] = 0; set_edge[i] = 0;
    end
    t0 = cyc;
    pulse_start();
    for (int k = 0; k < 120; k++) begin
      for (int b = 0; b < NB; b++) begin
        if (cyc - t0 == 10 + 30 * b) begin
          pg_i[b] = 1'b1;
          set_edge[b] = cyc + 1;
        end
      end
      tick();
      for (int b = 0; b < NB; b++) begin
        if (bank_en_o[b] && !seen[b]) begin
          seen[b] = 1'b1;
          rise[b] = cyc;
        end
      end
    end
    for (int b = 0; b < NB; b++) check("stag_latency", rise[b] - set_edge[b], 6);
    check("stag_done", int'(done_o), 1);

    // Supply loss on bank 2 in ACTIVE
    pg_i = 4'b1011;
    tickn(2);
    check("flt_not_yet", int'(fault_o), 0);
    tick();
    check("flt_bank_en", int'(bank_en_o), 0);
    check("flt_pad_oe", int'(pad_oe_o), 0);
    check("flt_fault", int'(fault_o), 1);
    check("flt_bank", int'(fault_bank_o), 2);
    pulse_start();
    tick();
    check("flt_start_ignored", int'(fault_o), 1);
    pg_i = 4'b1111;
    pulse_clear();
    tick();
    check("clr_fault", int'(fault_o), 0);
    check("clr_idle", int'(busy_o), 0);
    tickn(2);

    // stop_i during SETTLE of bank 2, settle=5
    settle_cyc_i = 8'd5;
    sticky_en = '0; sticky_oe = 1'b0;
    pulse_start();
    wait_for(3, 4'b0011, 100, "ss_reach_0011");
    tick();
    pulse_stop();
    check("ss_busy", int'(busy_o), 1);
    tickn(5);
    check("ss_hold", int'(bank_en_o), 3);
    tick();
    check("ss_step1", int'(bank_en_o), 1);
    tickn(5);
    check("ss_hold2", int'(bank_en_o), 1);
    tick();
    check("ss_step2", int'(bank_en_o), 0);
    tick();
    check("ss_idle", int'(busy_o), 0);
    check("ss_bank2_never", int'(sticky_en[2]), 0);
    check("ss_oe_never", int'(sticky_oe), 0);

    // Simultaneous stop_i and supply loss in ACTIVE
    settle_cyc_i = 8'd0;
    pulse_start();
    wait_for(0, '0, 100, "sim_reach_active");
    pg_i = 4'b1101;
    tickn(2);
    pulse_stop();
    check("sim_fault", int'(fault_o), 1);
    check("sim_bank", int'(fault_bank_o), 1);
    check("sim_not_shutdown", int'(busy_o), 0);
    pg_i = 4'b1111;
    pulse_clear();
    tickn(2);

    // Bank 1 supply never rises
    pg_i = 4'b0001; settle_cyc_i = 8'd2;
    tickn(3);
    pulse_start();
    wait_for(3, 4'b0001, 100, "to_bank0_up");
    e = cyc;
`ifdef IO_PWR_SEQ_TIMEOUT_EN
    wait_for(1, '0, 100, "to_fault");
    check("to_latency", cyc - e, TO);
    check("to_timeout", int'(timeout_o), 1);
    check("to_bank", int'(fault_bank_o), 1);
    check("to_bank_en", int'(bank_en_o), 0);
    pg_i = 4'b1111;
    pulse_clear();
`else
    tickn(60);
    check("nto_busy", int'(busy_o), 1);
    check("nto_bank_en", int'(bank_en_o), 1);
    check("nto_timeout", int'(timeout_o), 0);
    check("nto_fault", int'(fault_o), 0);
    pulse_stop();
`endif
    wait_for(2, '0, 100, "to_back_idle");

    // Asynchronous reset mid-sequence
    pg_i = 4'b1111; settle_cyc_i = 8'd3;
    tickn(3);
    pulse_start();
    wait_for(3, 4'b0011, 100, "ar_reach_0011");
    #3;
    rst_ni = 1'b0;
    #1;
    check("ar_bank_en", int'(bank_en_o), 0);
    check("ar_busy", int'(busy_o), 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Randomized traffic checked against the model every cycle
    for (int i = 0; i < 4000; i++) begin
      int r;
      if (m_mode == MIdle && $urandom_range(0, 7) == 0) settle_cyc_i = CW'($urandom_range(0, 6));
      r = int'($urandom_range(0, 199));
      if (r < 2) pg_i = NB'($urandom);
      else if (r < 30) pg_i = 4'b1111;
      start_i = ($urandom_range(0, 9) == 0);
      stop_i  = ($urandom_range(0, 59) == 0);
      clear_i = ($urandom_range(0, 11) == 0);
      tick();
    end
    start_i = 1'b0; stop_i = 1'b0; clear_i = 1'b0;
    tickn(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_pwr_seq.md
Name: io_pwr_seq

Overview:
- Power-up/power-down sequencer for the GF22FDX 1.8 V IO pad ring.
- Enables N pad banks one at a time, each gated by its own supply-good flag (VDDIO/VSUP detector), with a programmable settle delay between banks.
- Releases the global pad output-enable only when every bank is up.
- Detects supply loss on enabled banks and forces all banks into a fail-safe state.

Parameters:
- N_BANKS, 4, number of sequenced pad banks (2..16).
- CNT_W, 8, width of the settle-delay counter.
- TIMEOUT_CYC, 1024, power-good wait limit in cycles (used only with the optional feature).

Ports:
- clk_i  in  1  block clock.
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  pulse that begins power-up; sampled in IDLE only.
- stop_i  in  1  pulse that begins orderly power-down.
- clear_i  in  1  pulse that exits FAULT.
- pg_i  in  N_BANKS  per-bank supply-good flags; asynchronous.
- settle_cyc_i  in  CNT_W  settle delay per bank; quasi-static.
- bank_en_o  out  N_BANKS  per-bank enable (registered).
- pad_oe_o  out  1  global pad output enable (registered).
- busy_o  out  1  high in WAIT_PG, SETTLE, SHUTDOWN.
- done_o  out  1  high in ACTIVE.
- fault_o  out  1  high in FAULT.
- fault_bank_o  out  $clog2(N_BANKS)  index of the failing bank.
- timeout_o  out  1  fault cause is a power-good timeout.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, bank index 0, counter 0.
- pg_i passes through a 2-flop synchronizer, giving pg_s with 2 cycles of latency. All decisions use pg_s.
- IDLE:
  - start_i moves to WAIT_PG with idx=0.
  - stop_i and clear_i are ignored.
- WAIT_PG:
  - When pg_s[idx]=1, load cnt=settle_cyc_i and go to SETTLE.
- SETTLE:
  - cnt decrements each cycle.
  - In the cycle cnt==0, set bank_en_o[idx]=1 (visible next edge).
  - If idx==N_BANKS-1, go to ACTIVE; otherwise idx++ and go to WAIT_PG.
  - settle_cyc_i=0 gives one cycle in SETTLE.
- ACTIVE:
  - pad_oe_o=1 and done_o=1 from the first cycle in ACTIVE (registered on entry).
  - stop_i goes to SHUTDOWN.
- SHUTDOWN:
  - pad_oe_o clears on the entry edge.
  - Banks are disabled in reverse order (highest enabled first), one bank per settle_cyc_i+1 cycles.
  - Go to IDLE once bank_en_o==0.
- stop_i in WAIT_PG or SETTLE:
  - Go to SHUTDOWN.
  - Only the banks already enabled are unwound; a bank in SETTLE is never enabled.
- Fault:
  - Trigger: in any state except IDLE/FAULT, a bank with bank_en_o[i]=1 and pg_s[i]=0.
  - Next edge: state FAULT, bank_en_o=0, pad_oe_o=0, fault_o=1, fault_bank_o = lowest such i.
- FAULT:
  - Outputs hold.
  - clear_i goes to IDLE and clears fault_o, fault_bank_o, timeout_o.
  - start_i is ignored.
- Priority when events coincide: fault > stop_i > normal progression.
- Asynchronous reset mid-sequence drops all enables immediately. No unwinding.

Optional Feature:
- Macro: IO_PWR_SEQ_TIMEOUT_EN.
- With the macro defined:
  - A wait counter runs in WAIT_PG and reloads on each WAIT_PG entry.
  - After TIMEOUT_CYC cycles without pg_s[idx], go to FAULT with fault_bank_o=idx and timeout_o=1.
  - Enabled banks are cleared as for a normal fault.
- Without the macro:
  - WAIT_PG waits indefinitely.
  - timeout_o is tied 0.
  - No wait counter is synthesised.
  - The port list is unchanged.

Decomposition:
- Package io_pwr_seq_pkg:
  - State enum io_pwr_state_e (IDLE, WAIT_PG, SETTLE, ACTIVE, SHUTDOWN, FAULT).
  - SYNC_STAGES=2.
  - Helper function for the lowest set bit index.
- Sub-module io_pwr_seq_sync: parameterised-width multi-flop synchronizer for pg_i, async active-low reset to 0.

Test Plan:
- Normal power-up, settle=3, pg_i held at 1111:
  - start_i, then bank_en_o steps 0001, 0011, 0111, 1111, with 4 cycles between steps after the 2-cycle sync.
  - pad_oe_o=1 and done_o=1 after bank 3.
- Staggered supplies, pg_i bits rise at cycles 10/40/70/100:
  - Each bank_en_o bit rises exactly 2+settle+1 cycles after its pg_i edge.
  - Bank order is preserved.
- Fault in ACTIVE, drop pg_i[2]:
  - 2 sync cycles plus one edge later: bank_en_o=0000, pad_oe_o=0, fault_o=1, fault_bank_o=2.
  - clear_i returns to IDLE.
- stop_i during SETTLE of bank 2, settle=5:
  - pad_oe_o stays 0.
  - bank_en_o goes 0011 to 0001 to 0000, 6 cycles apart; bank 2 never asserts; then IDLE.
- Simultaneous stop_i and a pg drop in ACTIVE: FAULT is taken, not SHUTDOWN.
- With IO_PWR_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, pg_i[1] never rises:
  - fault_o=1, timeout_o=1, fault_bank_o=1 after 16 cycles in WAIT_PG.
  - Bank 0 is cleared.
  - Without the macro, the block stays in WAIT_PG with busy_o=1.
